ex_operand_stage: RTL and testbench

- ID/EX pipeline register and operand-select stage. It sits directly upstream of the execute ALU.
- It latches decoded instruction fields, resolves RAW hazards (forwarding plus load-use bubble), and drives ALUOP, Port_A and Port_B into the ALU.
- It also carries destination and control fields forward to the EX/MEM latch.
- It uses a valid/ready handshake on both sides.

---
 rtl/ex_operand_stage.sv | 239 +++++++++++++++++++++++
 tb/tb_ex_operand_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register and ALU operand select, with valid/ready handshakes on both sides.
// Define ALU_FORWARD_EN for MEM/WB forwarding plus load-use stalls; otherwise any pending RAW stalls.
module ex_operand_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          flush,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [3:0]    id_aluop,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [DW-1:0] id_rdata1,
    input  logic [DW-1:0] id_rdata2,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_shamt,
    input  logic [1:0]    id_alusrc,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          id_regwen,
    input  logic [RW-1:0] id_wsel,
    input  logic          mem_regwen,
    input  logic [RW-1:0] mem_wsel,
    input  logic [DW-1:0] mem_result,
    input  logic          wb_regwen,
    input  logic [RW-1:0] wb_wsel,
    input  logic [DW-1:0] wb_result,
    input  logic          ex_ready,
    output logic          ex_valid,
    output logic [3:0]    ALUOP,
    output logic [DW-1:0] Port_A,
    output logic [DW-1:0] Port_B,
    output logic [DW-1:0] ex_storedata,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_regwen,
    output logic [RW-1:0] ex_wsel,
    output logic          hazard_stall
);
    localparam logic [1:0] SRC_IMM   = 2'b01;
    localparam logic [1:0] SRC_SHIFT = 2'b10;

    logic          ex_valid_q, ex_valid_d;
    logic          memread_q, memread_d;
    logic          memwrite_q, memwrite_d;
    logic          regwen_q, regwen_d;
    logic [RW-1:0] wsel_q, wsel_d;
    logic [3:0]    aluop_q, aluop_d;
    logic [RW-1:0] rs_q, rs_d;
    logic [RW-1:0] rt_q, rt_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic [DW-1:0] rdata2_q, rdata2_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [4:0]    shamt_q, shamt_d;
    logic [1:0]    alusrc_q, alusrc_d;

    logic          adv_s;
    logic          hz_s;
    logic [DW-1:0] fwd_rs_s;
    logic [DW-1:0] fwd_rt_s;
    logic [DW-1:0] op_a_s;
    logic [DW-1:0] op_b_s;

    assign adv_s = !ex_valid_q || ex_ready;

`ifdef ALU_FORWARD_EN
    function automatic logic [DW-1:0] fwd_val(
        input logic [RW-1:0] r,
        input logic [DW-1:0] rdata,
        input logic          m_wen,
        input logic [RW-1:0] m_sel,
        input logic [DW-1:0] m_res,
        input logic          w_wen,
        input logic [RW-1:0] w_sel,
        input logic [DW-1:0] w_res
    );
        if (m_wen && (m_sel == r) && (r != {RW{1'b0}})) begin
            fwd_val = m_res;
        end else if (w_wen && (w_sel == r) && (r != {RW{1'b0}})) begin
            fwd_val = w_res;
        end else begin
            fwd_val = rdata;
        end
    endfunction

    // A load in this stage cannot forward until it reaches MEM, so its consumer waits one cycle.
    always_comb begin
        hz_s = ex_valid_q && memread_q && regwen_q && (wsel_q != {RW{1'b0}}) &&
               ((wsel_q == id_rs) || ((wsel_q == id_rt) && (id_alusrc != SRC_IMM)));
    end

    // Forwarded operand values, MEM ahead of WB.
    always_comb begin
        fwd_rs_s = fwd_val(rs_q, rdata1_q, mem_regwen, mem_wsel, mem_result,
                           wb_regwen, wb_wsel, wb_result);
        fwd_rt_s = fwd_val(rt_q, rdata2_q, mem_regwen, mem_wsel, mem_result,
                           wb_regwen, wb_wsel, wb_result);
    end
`else
    logic fwd_unused_s;

    function automatic logic raw_hit(
        input logic          wen,
        input logic [RW-1:0] w_sel,
        input logic [RW-1:0] rs,
        input logic [RW-1:0] rt
    );
        raw_hit = wen && (w_sel != {RW{1'b0}}) && ((w_sel == rs) || (w_sel == rt));
    endfunction

    // Without forwarding, any in-flight writer of a source register holds decode back.
    always_comb begin
        hz_s = raw_hit(ex_valid_q && regwen_q, wsel_q, id_rs, id_rt) ||
               raw_hit(mem_regwen, mem_wsel, id_rs, id_rt) ||
               raw_hit(wb_regwen, wb_wsel, id_rs, id_rt);
    end

    // Operands come straight from the latched register-file data.
    always_comb begin
        fwd_rs_s = rdata1_q;
        fwd_rt_s = rdata2_q;
    end

    assign fwd_unused_s = ^{mem_result, wb_result, rs_q, rt_q};
`endif

    assign id_ready     = adv_s && !hz_s;
    assign hazard_stall = id_valid && hz_s && adv_s;

    // Next-state selection: flush, then bubble, then load, else hold.
    always_comb begin
        ex_valid_d = ex_valid_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        regwen_d   = regwen_q;
        wsel_d     = wsel_q;
        aluop_d    = aluop_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rdata1_d   = rdata1_q;
        rdata2_d   = rdata2_q;
        imm_d      = imm_q;
        shamt_d    = shamt_q;
        alusrc_d   = alusrc_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (adv_s && hz_s) begin
            ex_valid_d = 1'b0;
        end else if (adv_s) begin
            ex_valid_d = id_valid;
            memread_d  = id_memread;
            memwrite_d = id_memwrite;
            regwen_d   = id_regwen;
            wsel_d     = id_wsel;
            aluop_d    = id_aluop;
            rs_d       = id_rs;
            rt_d       = id_rt;
            rdata1_d   = id_rdata1;
            rdata2_d   = id_rdata2;
            imm_d      = id_imm;
            shamt_d    = id_shamt;
            alusrc_d   = id_alusrc;
        end else begin
            ex_valid_d = ex_valid_q;
        end
    end

    // Pipeline register with asynchronous clear.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ex_valid_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            regwen_q   <= 1'b0;
            wsel_q     <= {RW{1'b0}};
            aluop_q    <= 4'b0000;
            rs_q       <= {RW{1'b0}};
            rt_q       <= {RW{1'b0}};
            rdata1_q   <= {DW{1'b0}};
            rdata2_q   <= {DW{1'b0}};
            imm_q      <= {DW{1'b0}};
            shamt_q    <= 5'b00000;
            alusrc_q   <= 2'b00;
        end else begin
            ex_valid_q <= ex_valid_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            regwen_q   <= regwen_d;
            wsel_q     <= wsel_d;
            aluop_q    <= aluop_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rdata1_q   <= rdata1_d;
            rdata2_q   <= rdata2_d;
            imm_q      <= imm_d;
            shamt_q    <= shamt_d;
            alusrc_q   <= alusrc_d;
        end
    end

    // Operand select; an empty stage presents zeros so the ALU idles on a harmless AND.
    always_comb begin
        op_a_s = fwd_rs_s;
        op_b_s = fwd_rt_s;
        case (alusrc_q)
            SRC_IMM: begin
                op_a_s = fwd_rs_s;
                op_b_s = imm_q;
            end
            SRC_SHIFT: begin
                op_a_s = fwd_rt_s;
                op_b_s = {{(DW-5){1'b0}}, shamt_q};
            end
            default: begin
                op_a_s = fwd_rs_s;
                op_b_s = fwd_rt_s;
            end
        endcase
        if (ex_valid_q) begin
            ALUOP  = aluop_q;
            Port_A = op_a_s;
            Port_B = op_b_s;
        end else begin
            ALUOP  = 4'b0000;
            Port_A = {DW{1'b0}};
            Port_B = {DW{1'b0}};
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_storedata = fwd_rt_s;
    assign ex_memread   = memread_q;
    assign ex_memwrite  = memwrite_q;
    assign ex_regwen    = regwen_q;
    assign ex_wsel      = wsel_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: table vectors through a scoreboard queue,
// plus hand sequences for reset, load-use, flush and back-pressure.
module tb_ex_operand_stage;
`ifdef ALU_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        CLK, nRST, flush, id_valid, id_ready;
    logic [3:0]  id_aluop;
    logic [4:0]  id_rs, id_rt, id_wsel, id_shamt;
    logic [31:0] id_rdata1, id_rdata2, id_imm;
    logic [1:0]  id_alusrc;
    logic        id_memread, id_memwrite, id_regwen;
    logic        mem_regwen, wb_regwen, ex_ready;
    logic [4:0]  mem_wsel, wb_wsel;
    logic [31:0] mem_result, wb_result;
    logic        ex_valid, ex_memread, ex_memwrite, ex_regwen, hazard_stall;
    logic [3:0]  ALUOP;
    logic [31:0] Port_A, Port_B, ex_storedata;
    logic [4:0]  ex_wsel;

    ex_operand_stage #(.DW(32), .RW(5)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
        .id_aluop(id_aluop), .id_rs(id_rs), .id_rt(id_rt), .id_rdata1(id_rdata1),
        .id_rdata2(id_rdata2), .id_imm(id_imm), .id_shamt(id_shamt), .id_alusrc(id_alusrc),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_regwen(id_regwen),
        .id_wsel(id_wsel), .mem_regwen(mem_regwen), .mem_wsel(mem_wsel),
        .mem_result(mem_result), .wb_regwen(wb_regwen), .wb_wsel(wb_wsel),
        .wb_result(wb_result), .ex_ready(ex_ready), .ex_valid(ex_valid), .ALUOP(ALUOP),
        .Port_A(Port_A), .Port_B(Port_B), .ex_storedata(ex_storedata),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_regwen(ex_regwen),
        .ex_wsel(ex_wsel), .hazard_stall(hazard_stall)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  aluop;
        logic [1:0]  alusrc;
        logic [4:0]  rs, rt;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  shamt, wsel;
        logic        mrw;
        logic [4:0]  mws;
        logic [31:0] mres;
        logic        wrw;
        logic [4:0]  wws;
        logic [31:0] wres;
        logic [31:0] ea, eb, esd;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];
    vec_t sb [$];
    vec_t e;
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_id(input logic [3:0] op, input logic [1:0] src, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [31:0] rd1, input logic [31:0] rd2,
                            input logic [31:0] imm, input logic [4:0] sh, input logic [4:0] ws,
                            input logic mr, input logic rw);
        id_aluop = op; id_alusrc = src; id_rs = rs; id_rt = rt; id_rdata1 = rd1;
        id_rdata2 = rd2; id_imm = imm; id_shamt = sh; id_wsel = ws; id_memread = mr;
        id_memwrite = 1'b0; id_regwen = rw;
    endtask

    initial begin
        // aluop src rs rt rd1 rd2 imm shamt wsel | mem rw/sel/res | wb rw/sel/res | expected A, B, storedata
        vecs[0] = '{4'b0010, 2'b00, 5'd1, 5'd2, 32'h5, 32'h7, 32'h0, 5'd0, 5'd9,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h5, 32'h7, 32'h7};
        vecs[1] = '{4'b0010, 2'b00, 5'd3, 5'd0, 32'h11, 32'h22, 32'h0, 5'd0, 5'd3,
                    1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB,
                    FWD ? 32'hAA : 32'h11, 32'h22, 32'h22};
        vecs[2] = '{4'b0110, 2'b00, 5'd0, 5'd5, 32'h33, 32'h44, 32'h0, 5'd0, 5'd1,
                    1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB, 32'h33, 32'h44, 32'h44};
        vecs[3] = '{4'b0001, 2'b00, 5'd6, 5'd7, 32'h1, 32'h2, 32'h0, 5'd0, 5'd2,
                    1'b1, 5'd9, 32'hAA, 1'b1, 5'd7, 32'hBB,
                    32'h1, FWD ? 32'hBB : 32'h2, FWD ? 32'hBB : 32'h2};
        vecs[4] = '{4'b1000, 2'b10, 5'd2, 5'd1, 32'h99, 32'h1, 32'h0, 5'd4, 5'd3,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h1, 32'h4, 32'h1};
        vecs[5] = '{4'b1001, 2'b10, 5'd0, 5'd8, 32'h0, 32'h3, 32'h0, 5'd31, 5'd4,
                    1'b1, 5'd8, 32'hCAFE, 1'b1, 5'd8, 32'hBEEF,
                    FWD ? 32'hCAFE : 32'h3, 32'd31, FWD ? 32'hCAFE : 32'h3};
        vecs[6] = '{4'b0000, 2'b01, 5'd10, 5'd11, 32'h100, 32'h200, 32'hFFFF_FFF0, 5'd0, 5'd5,
                    1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'h77,
                    32'h100, 32'hFFFF_FFF0, FWD ? 32'h77 : 32'h200};
        vecs[7] = '{4'b0111, 2'b11, 5'd12, 5'd13, 32'hA, 32'hB, 32'h5, 5'd7, 5'd6,
                    1'b1, 5'd13, 32'hC, 1'b0, 5'd0, 32'h0,
                    32'hA, FWD ? 32'hC : 32'hB, FWD ? 32'hC : 32'hB};

        nRST = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
        drive_id(4'b0000, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
        mem_regwen = 1'b0; mem_wsel = 5'd0; mem_result = 32'h0;
        wb_regwen = 1'b0; wb_wsel = 5'd0; wb_result = 32'h0;
        #2;
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
        chk("rst_port_a", Port_A, 32'h0);
        chk("rst_port_b", Port_B, 32'h0);
        chk("rst_aluop", {28'b0, ALUOP}, 32'h0);
        chk("rst_storedata", ex_storedata, 32'h0);
        chk("rst_hazard", {31'b0, hazard_stall}, 32'h0);
        tick(); tick();
        nRST = 1'b1;
        tick();

        // Table vectors: accept, present MEM/WB state, compare, drain.
        for (int i = 0; i < NV; i++) begin
            drive_id(vecs[i].aluop, vecs[i].alusrc, vecs[i].rs, vecs[i].rt, vecs[i].rd1,
                     vecs[i].rd2, vecs[i].imm, vecs[i].shamt, vecs[i].wsel, 1'b0, 1'b1);
            id_valid = 1'b1; mem_regwen = 1'b0; wb_regwen = 1'b0;
            sb.push_back(vecs[i]);
            tick();
            id_valid = 1'b0;
            mem_regwen = vecs[i].mrw; mem_wsel = vecs[i].mws; mem_result = vecs[i].mres;
            wb_regwen = vecs[i].wrw; wb_wsel = vecs[i].wws; wb_result = vecs[i].wres;
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_valid", i), {31'b0, ex_valid}, 32'h1);
            chk($sformatf("v%0d_port_a", i), Port_A, e.ea);
            chk($sformatf("v%0d_port_b", i), Port_B, e.eb);
            chk($sformatf("v%0d_storedata", i), ex_storedata, e.esd);
            chk($sformatf("v%0d_aluop", i), {28'b0, ALUOP}, {28'b0, e.aluop});
            chk($sformatf("v%0d_wsel", i), {27'b0, ex_wsel}, {27'b0, e.wsel});
            mem_regwen = 1'b0; wb_regwen = 1'b0;
            tick();
            chk($sformatf("v%0d_drain", i), {31'b0, ex_valid}, 32'h0);
        end

        // Load-use: lw $4 in the stage, consumer reads $4.
        drive_id(4'b0010, 2'b01, 5'd1, 5'd0, 32'h10, 32'h0, 32'h4, 5'd0, 5'd4, 1'b1, 1'b1);
        id_valid = 1'b1;
        tick();
        chk("lw_memread", {31'b0, ex_memread}, 32'h1);
        drive_id(4'b0010, 2'b00, 5'd4, 5'd0, 32'h55, 32'h0, 32'h0, 5'd0, 5'd7, 1'b0, 1'b1);
        #1;
        chk("lu_id_ready", {31'b0, id_ready}, 32'h0);
        chk("lu_hazard", {31'b0, hazard_stall}, 32'h1);
        tick();
        chk("lu_bubble", {31'b0, ex_valid}, 32'h0);
        mem_regwen = 1'b1; mem_wsel = 5'd4; mem_result = 32'hDEAD;
        #1;
        if (FWD) begin
            chk("lu_ready_after", {31'b0, id_ready}, 32'h1);
            tick();
            chk("lu_accept", {31'b0, ex_valid}, 32'h1);
            chk("lu_port_a", Port_A, 32'hDEAD);
        end else begin
            chk("dep_mem_hazard", {31'b0, hazard_stall}, 32'h1);
            tick();
            chk("dep_mem_bubble", {31'b0, ex_valid}, 32'h0);
            mem_regwen = 1'b0; wb_regwen = 1'b1; wb_wsel = 5'd4; wb_result = 32'hBEEF;
            #1;
            chk("dep_wb_hazard", {31'b0, hazard_stall}, 32'h1);
            tick();
            wb_regwen = 1'b0;
            #1;
            chk("dep_clear_ready", {31'b0, id_ready}, 32'h1);
            tick();
            chk("dep_accept", {31'b0, ex_valid}, 32'h1);
            chk("dep_port_a", Port_A, 32'h55);
        end
        id_valid = 1'b0; mem_regwen = 1'b0; wb_regwen = 1'b0;
        tick();

        // Flush beats a simultaneous accept.
        drive_id(4'b0010, 2'b00, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 5'd0, 5'd3, 1'b0, 1'b0);
        id_valid = 1'b1;
        tick();
        chk("pre_flush_valid", {31'b0, ex_valid}, 32'h1);
        drive_id(4'b0110, 2'b00, 5'd5, 5'd6, 32'h8, 32'h9, 32'h0, 5'd0, 5'd3, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", {31'b0, ex_valid}, 32'h0);
        chk("flush_aluop", {28'b0, ALUOP}, 32'h0);
        chk("flush_port_a", Port_A, 32'h0);

        // Back-pressure: everything holds while ex_ready is low.
        drive_id(4'b0110, 2'b00, 5'd1, 5'd2, 32'h123, 32'h456, 32'h0, 5'd0, 5'd3, 1'b0, 1'b0);
        tick();
        ex_ready = 1'b0;
        drive_id(4'b0001, 2'b00, 5'd5, 5'd6, 32'h777, 32'h888, 32'h0, 5'd0, 5'd9, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("hold%0d_valid", c), {31'b0, ex_valid}, 32'h1);
            chk($sformatf("hold%0d_port_a", c), Port_A, 32'h123);
            chk($sformatf("hold%0d_port_b", c), Port_B, 32'h456);
            chk($sformatf("hold%0d_aluop", c), {28'b0, ALUOP}, 32'h6);
            chk($sformatf("hold%0d_id_ready", c), {31'b0, id_ready}, 32'h0);
        end
        ex_ready = 1'b1;
        tick();
        chk("release_port_a", Port_A, 32'h777);
        chk("release_wsel", {27'b0, ex_wsel}, 32'd9);

        // Asynchronous reset with a live instruction, checked before any clock edge.
        #2;
        nRST = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, ex_valid}, 32'h0);
        chk("async_rst_port_a", Port_A, 32'h0);
        chk("async_rst_port_b", Port_B, 32'h0);
        chk("async_rst_aluop", {28'b0, ALUOP}, 32'h0);
        chk("async_rst_wsel", {27'b0, ex_wsel}, 32'h0);
        id_valid = 1'b0;
        tick();
        nRST = 1'b1;
        tick();
        chk("post_rst_empty", {31'b0, ex_valid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
